// File: rtl/alu_result_bcd_pkg.sv
// Shared definitions for the ALU result BCD converter and its display stages.
// Holds the FSM state encodings and the BCD digit constants.
package alu_result_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcdState_e;

  localparam int          BCD_DIGIT_W    = 4;
  localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0]  ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/alu_result_bcd_add3.sv
// Double-dabble correction cell for one BCD digit: adds 3 when the digit is 5 or more.
module bcd_add3
  import alu_result_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digitIn,
  output logic [BCD_DIGIT_W-1:0] digitOut
);

  assign digitOut = (digitIn >= ADD3_THRESHOLD) ? (digitIn + ADD3_VALUE) : digitIn;

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential binary-to-BCD converter downstream of the ALU; captures Y plus
// carry/overflow status and presents packed BCD through a valid/ready handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for in_valid to capture a result
// ST_SHIFT | one shift-add-3 iteration per cycle, count runs WIDTH..1
// ST_DONE  | out_valid high, outputs held until out_ready
module alu_result_bcd
  import alu_result_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_y,
  input  logic                        in_carry,
  input  logic                        in_ovf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                        out_carry,
  output logic                        out_ovf
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  bcdState_e       state;
  bcdState_e       stateNext;
  logic            loadEn;
  logic            iterEn;
  logic [WIDTH-1:0] shiftReg;
  logic [BW-1:0]   accReg;
  logic [BW-1:0]   accCorr;
  logic [BW-1:0]   accShifted;
  logic [CW-1:0]   count;
  logic [BW-1:0]   bcdReg;
  logic            carryReg;
  logic            ovfReg;
  logic            lastIter;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gDigit
      bcd_add3 uAdd3 (
        .digitIn  (accReg[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digitOut (accCorr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The digit-count rule guarantees the bit shifted out of the accumulator top is zero.
  assign accShifted = (accCorr << 1) | {{(BW-1){1'b0}}, shiftReg[WIDTH-1]};
  assign lastIter   = (count == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    loadEn    = 1'b0;
    iterEn    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          loadEn    = 1'b1;
          stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        iterEn = 1'b1;
        if (lastIter) stateNext = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      accReg   <= '0;
      count    <= '0;
      bcdReg   <= '0;
      carryReg <= 1'b0;
      ovfReg   <= 1'b0;
    end else if (loadEn) begin
      shiftReg <= in_y;
      accReg   <= '0;
      count    <= CW'(WIDTH);
      carryReg <= in_carry;
      ovfReg   <= in_ovf;
    end else if (iterEn) begin
      shiftReg <= shiftReg << 1;
      accReg   <= accShifted;
      count    <= count - CW'(1);
      // Output register only sees finished conversions.
      if (lastIter) bcdReg <= accShifted;
    end
  end

  assign bcd       = bcdReg;
  assign out_carry = carryReg;
  assign out_ovf   = ovfReg;

endmodule
